// File: rtl/result_deframer_if.sv
// Byte-in / correction-word-out handshake bundle for the result deframer.
// The slave side is the deframer, and the master side is whatever feeds and drains it.
interface result_deframer_if #(
    parameter int CORRECTION_WIDTH = 14,
    parameter int GRID_WIDTH_U     = 3
);
    localparam int U_BIT_WIDTH = (GRID_WIDTH_U > 1) ? $clog2(GRID_WIDTH_U) : 1;

    logic [7:0]                  in_data;
    logic                        in_valid;
    logic                        in_ready;
    logic [CORRECTION_WIDTH-1:0] corr_data;
    logic [U_BIT_WIDTH-1:0]      corr_round;
    logic                        corr_last;
    logic                        corr_valid;
    logic                        corr_ready;

    modport master (
        output in_data, in_valid, corr_ready,
        input  in_ready, corr_data, corr_round, corr_last, corr_valid
    );

    modport slave (
        input  in_data, in_valid, corr_ready,
        output in_ready, corr_data, corr_round, corr_last, corr_valid
    );
endinterface

// File: rtl/result_deframer.sv
// Splits control-node result frames (3 header bytes plus GRID_WIDTH_U correction words)
// into a valid/ready word stream. It latches per-frame statistics and aborts stalled frames.
module result_deframer #(
    parameter int CORRECTION_WIDTH = 14,
    parameter int GRID_WIDTH_U     = 3,
    parameter int TIMEOUT_CYCLES   = 1024
) (
    input  logic                clk,
    input  logic                reset,
    result_deframer_if.slave    bus,
    output logic [7:0]          iteration_count,
    output logic [15:0]         cycle_count,
    output logic                frame_done,
    output logic                frame_error,
    output logic [15:0]         frame_count
);
    localparam int CORR_BYTES  = (CORRECTION_WIDTH + 7) >> 3;
    localparam int U_BIT_WIDTH = (GRID_WIDTH_U > 1) ? $clog2(GRID_WIDTH_U) : 1;
    localparam int B_W         = (CORR_BYTES > 1) ? $clog2(CORR_BYTES) : 1;
    localparam int WD_W        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int WD_LIM_I    = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    localparam logic [WD_W-1:0]        WD_LIM = WD_W'(WD_LIM_I);
    localparam logic [B_W-1:0]         B_LAST = B_W'(CORR_BYTES - 1);
    localparam logic [U_BIT_WIDTH-1:0] U_LAST = U_BIT_WIDTH'(GRID_WIDTH_U - 1);

    typedef enum logic [1:0] {S_ITER, S_CYC_HI, S_CYC_LO, S_PAYLOAD} state_t;

    state_t                    state;
    logic [7:0]                iter_sh, hi_sh, lo_sh;
    logic [B_W-1:0]            byte_idx;
    logic [U_BIT_WIDTH-1:0]    round_idx;
    logic [CORR_BYTES*8-1:0]   partial, next_word;
    logic [WD_W-1:0]           wd_cnt;
    logic                      word_end, drain, accept, wd_expire;

    assign word_end     = (state == S_PAYLOAD) && (byte_idx == B_LAST);
    assign drain        = bus.corr_valid && bus.corr_ready;
    // Only a word-completing byte needs buffer space; a same-cycle drain frees it.
    assign bus.in_ready = !(word_end && bus.corr_valid && !bus.corr_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    // Counting needs !in_valid, so a same-cycle byte always beats the abort.
    assign wd_expire    = (TIMEOUT_CYCLES != 0) && (state != S_ITER) && bus.in_ready &&
                          !bus.in_valid && (wd_cnt == WD_LIM);

    always_comb begin
        next_word = partial;
        for (int k = 0; k < CORR_BYTES; k++)
            if (byte_idx == B_W'(k)) next_word[8*k +: 8] = bus.in_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= S_ITER;
            iter_sh         <= '0;
            hi_sh           <= '0;
            lo_sh           <= '0;
            byte_idx        <= '0;
            round_idx       <= '0;
            partial         <= '0;
            wd_cnt          <= '0;
            bus.corr_valid  <= 1'b0;
            bus.corr_data   <= '0;
            bus.corr_round  <= '0;
            bus.corr_last   <= 1'b0;
            iteration_count <= '0;
            cycle_count     <= '0;
            frame_done      <= 1'b0;
            frame_error     <= 1'b0;
            frame_count     <= '0;
        end else begin
            frame_done  <= 1'b0;
            frame_error <= 1'b0;
            if (drain) bus.corr_valid <= 1'b0;

            if (accept) begin
                wd_cnt <= '0;
                unique case (state)
                    S_ITER: begin
                        iter_sh <= bus.in_data;
                        state   <= S_CYC_HI;
                    end
                    S_CYC_HI: begin
                        hi_sh <= bus.in_data;
                        state <= S_CYC_LO;
                    end
                    S_CYC_LO: begin
                        lo_sh <= bus.in_data;
                        state <= S_PAYLOAD;
                    end
                    S_PAYLOAD: begin
                        if (word_end) begin
                            bus.corr_valid <= 1'b1;
                            bus.corr_data  <= next_word[CORRECTION_WIDTH-1:0];
                            bus.corr_round <= round_idx;
                            bus.corr_last  <= (round_idx == U_LAST);
                            partial        <= '0;
                            byte_idx       <= '0;
                            if (round_idx == U_LAST) begin
                                round_idx       <= '0;
                                state           <= S_ITER;
                                frame_done      <= 1'b1;
                                frame_count     <= frame_count + 16'd1;
                                iteration_count <= iter_sh;
                                cycle_count     <= {hi_sh, lo_sh};
                            end else begin
                                round_idx <= round_idx + 1'b1;
                            end
                        end else begin
                            partial  <= next_word;
                            byte_idx <= byte_idx + 1'b1;
                        end
                    end
                endcase
            end else if (state == S_ITER) begin
                wd_cnt <= '0;
            end else if (wd_expire) begin
                // Drop the partial frame but keep any finished word in the buffer.
                frame_error <= 1'b1;
                state       <= S_ITER;
                byte_idx    <= '0;
                round_idx   <= '0;
                partial     <= '0;
                wd_cnt      <= '0;
            end else if (bus.in_ready && !bus.in_valid) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_result_deframer.sv
// Directed bench for result_deframer. A frame-level model predicts the words and statistics,
// and a per-cycle monitor compares the DUT against it alongside literal spot checks.
module tb_result_deframer;
    localparam int CW = 14;
    localparam int GU = 3;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    result_deframer_if #(.CORRECTION_WIDTH(CW), .GRID_WIDTH_U(GU)) bus ();

    logic [7:0]  iteration_count;
    logic [15:0] cycle_count;
    logic        frame_done;
    logic        frame_error;
    logic [15:0] frame_count;

    result_deframer #(.CORRECTION_WIDTH(CW), .GRID_WIDTH_U(GU), .TIMEOUT_CYCLES(TO)) dut (
        .clk             (clk),
        .reset           (reset),
        .bus             (bus),
        .iteration_count (iteration_count),
        .cycle_count     (cycle_count),
        .frame_done      (frame_done),
        .frame_error     (frame_error),
        .frame_count     (frame_count)
    );

    typedef struct packed { logic [CW-1:0] d; logic [1:0] r; logic l; } word_t;
    typedef struct packed { logic [7:0] it; logic [15:0] cy; } stat_t;

    word_t       exp_w[$];
    stat_t       exp_s[$];
    logic [CW-1:0] seen[$];
    logic [15:0] fc_at_done[$];
    int          total = 0;
    int          bad = 0;
    int          done_pulses = 0;
    int          err_pulses = 0;
    logic [7:0]  m_iter = '0;
    logic [15:0] m_cyc = '0;
    logic [15:0] m_fc = '0;
    logic        hold = 1'b0;
    word_t       held;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic acc;
        int   n;
        acc = 1'b0;
        n = 0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = bus.in_ready;
            tick();
            n++;
        end
        chk("byte_accepted", {31'd0, acc}, 1);
        bus.in_valid = 1'b0;
    endtask

    // raw words are the two payload bytes as {second, first}; gap idles after the first payload byte
    task automatic send_frame(input logic [7:0] it, input logic [15:0] cy,
                              input logic [15:0] w0, input logic [15:0] w1,
                              input logic [15:0] w2, input int gap);
        logic [15:0] raw[3];
        word_t w;
        raw = '{w0, w1, w2};
        for (int r = 0; r < GU; r++) begin
            w.d = CW'(int'(raw[r]) % (1 << CW));
            w.r = 2'(r);
            w.l = (r == GU - 1);
            exp_w.push_back(w);
        end
        exp_s.push_back('{it: it, cy: cy});
        send_byte(it);
        send_byte(cy[15:8]);
        send_byte(cy[7:0]);
        for (int r = 0; r < GU; r++) begin
            send_byte(raw[r][7:0]);
            if (r == 0 && gap > 0) idle(gap);
            send_byte(raw[r][15:8]);
        end
    endtask

    task automatic monitor_step();
        stat_t s;
        word_t w;
        word_t cur;
        if (!reset) begin
            chk("rst_corr_valid", {31'd0, bus.corr_valid}, 0);
            chk("rst_in_ready", {31'd0, bus.in_ready}, 1);
            chk("rst_frame_count", {16'd0, frame_count}, 0);
            chk("rst_stats", {8'd0, iteration_count, cycle_count}, 0);
            m_iter = '0;
            m_cyc  = '0;
            m_fc   = '0;
            hold   = 1'b0;
            exp_w.delete();
            exp_s.delete();
            return;
        end
        if (frame_done) begin
            done_pulses++;
            fc_at_done.push_back(frame_count);
            chk("frame_done_expected", {31'd0, exp_s.size() > 0}, 1);
            if (exp_s.size() > 0) begin
                s = exp_s.pop_front();
                m_iter = s.it;
                m_cyc  = s.cy;
            end
            m_fc = m_fc + 16'd1;
        end
        if (frame_error) err_pulses++;
        chk("iteration_count", {24'd0, iteration_count}, {24'd0, m_iter});
        chk("cycle_count", {16'd0, cycle_count}, {16'd0, m_cyc});
        chk("frame_count", {16'd0, frame_count}, {16'd0, m_fc});
        cur = '{d: bus.corr_data, r: bus.corr_round, l: bus.corr_last};
        if (hold) begin
            chk("hold_valid", {31'd0, bus.corr_valid}, 1);
            chk("hold_word", 32'(cur), 32'(held));
        end
        if (bus.corr_valid && bus.corr_ready) begin
            chk("word_expected", {31'd0, exp_w.size() > 0}, 1);
            if (exp_w.size() > 0) begin
                w = exp_w.pop_front();
                chk("corr_data", 32'(bus.corr_data), 32'(w.d));
                chk("corr_round", 32'(bus.corr_round), 32'(w.r));
                chk("corr_last", 32'(bus.corr_last), 32'(w.l));
            end
            seen.push_back(bus.corr_data);
        end
        hold = bus.corr_valid && !bus.corr_ready;
        held = cur;
    endtask

    task automatic run_tests();
        int base;
        int dbase;
        // reset
        repeat (3) tick();
        reset = 1'b1;
        tick();

        // 1: basic frame, free-flowing output
        bus.corr_ready = 1'b1;
        base = seen.size();
        send_frame(8'h05, 16'h012C, 16'h1ABC, 16'h0001, 16'h3FFF, 0);
        idle(3);
        chk("t1_word0", 32'(seen[base]), 32'h1ABC);
        chk("t1_word1", 32'(seen[base+1]), 32'h0001);
        chk("t1_word2", 32'(seen[base+2]), 32'h3FFF);
        chk("t1_iter", {24'd0, iteration_count}, 32'h05);
        chk("t1_cyc", {16'd0, cycle_count}, 32'h012C);
        chk("t1_fc", {16'd0, frame_count}, 1);
        chk("t1_done_pulses", done_pulses, 1);

        // 2: downstream stalled; second word-completing byte is held off
        bus.corr_ready = 1'b0;
        base = seen.size();
        fork
            send_frame(8'h05, 16'h012C, 16'h1ABC, 16'h0001, 16'h3FFF, 0);
            begin
                repeat (12) @(negedge clk);
                chk("t2_in_ready_low", {31'd0, bus.in_ready}, 0);
                chk("t2_pending_byte", {24'd0, bus.in_data}, 32'h00);
                chk("t2_held_word", 32'(bus.corr_data), 32'h1ABC);
                chk("t2_held_valid", {31'd0, bus.corr_valid}, 1);
                @(posedge clk);
                #1 bus.corr_ready = 1'b1;
            end
        join
        idle(4);
        chk("t2_word0", 32'(seen[base]), 32'h1ABC);
        chk("t2_word1", 32'(seen[base+1]), 32'h0001);
        chk("t2_word2", 32'(seen[base+2]), 32'h3FFF);
        chk("t2_fc", {16'd0, frame_count}, 2);

        // 3: high byte FF truncated to 14 bits; 7-cycle gap stays under the watchdog
        base = seen.size();
        send_frame(8'h09, 16'h0010, 16'hFF34, 16'h8000, 16'hC0FF, TO - 1);
        idle(3);
        chk("t3_trunc_ff", 32'(seen[base]), 32'h3F34);
        chk("t3_trunc_80", 32'(seen[base+1]), 32'h0000);
        chk("t3_trunc_c0", 32'(seen[base+2]), 32'h00FF);
        chk("t3_no_error", err_pulses, 0);
        chk("t3_fc", {16'd0, frame_count}, 3);

        // 4: watchdog abort after header bytes, then a clean frame
        send_byte(8'h05);
        send_byte(8'h01);
        idle(TO);
        idle(2);
        chk("t4_error_pulses", err_pulses, 1);
        chk("t4_fc_unchanged", {16'd0, frame_count}, 3);
        chk("t4_iter_unchanged", {24'd0, iteration_count}, 32'h09);
        send_frame(8'h0A, 16'h0BCD, 16'h0102, 16'h0304, 16'h0506, 0);
        idle(3);
        chk("t4_fc", {16'd0, frame_count}, 4);
        chk("t4_iter", {24'd0, iteration_count}, 32'h0A);

        // 5: asynchronous reset mid-payload with a buffered word
        bus.corr_ready = 1'b0;
        send_byte(8'h0B);
        send_byte(8'h00);
        send_byte(8'h10);
        send_byte(8'hBC);
        send_byte(8'h1A);
        send_byte(8'h01);
        @(negedge clk);
        chk("t5_pre_valid", {31'd0, bus.corr_valid}, 1);
        #2 reset = 1'b0;
        #1;
        chk("t5_async_valid", {31'd0, bus.corr_valid}, 0);
        chk("t5_async_ready", {31'd0, bus.in_ready}, 1);
        chk("t5_async_fc", {16'd0, frame_count}, 0);
        repeat (2) tick();
        reset = 1'b1;
        bus.corr_ready = 1'b1;
        tick();
        base = seen.size();
        send_frame(8'h0C, 16'h1122, 16'h2233, 16'h0044, 16'h1055, 0);
        idle(3);
        chk("t5_word0", 32'(seen[base]), 32'h2233);
        chk("t5_fc", {16'd0, frame_count}, 1);
        chk("t5_iter", {24'd0, iteration_count}, 32'h0C);

        // 6: frame counter wrap with back-to-back frames
        force dut.frame_count = 16'hFFFF;
        #1;
        release dut.frame_count;
        m_fc = 16'hFFFF;
        tick();
        dbase = fc_at_done.size();
        send_frame(8'h0D, 16'hBEEF, 16'h0011, 16'h0022, 16'h0033, 0);
        send_frame(8'h0E, 16'h0102, 16'h0044, 16'h0055, 16'h0066, 0);
        idle(3);
        chk("t6_wrap", {16'd0, fc_at_done[dbase]}, 0);
        chk("t6_after_wrap", {16'd0, fc_at_done[dbase+1]}, 1);
        chk("t6_iter", {24'd0, iteration_count}, 32'h0E);
        chk("t6_cyc", {16'd0, cycle_count}, 32'h0102);

        chk("end_words_drained", exp_w.size(), 0);
        chk("end_error_pulses", err_pulses, 1);
    endtask

    initial begin
        bus.in_data    = '0;
        bus.in_valid   = 1'b0;
        bus.corr_ready = 1'b0;
        fork
            forever begin
                @(negedge clk);
                monitor_step();
            end
            run_tests();
            begin
                #500000;
                total++;
                bad++;
                $display("FAIL global_timeout: bench did not complete in time");
            end
        join_any
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
